johnson_counter_param: RTL and testbench
========================================

# johnson_counter_param

Parametrised twisted-ring (Johnson) counter core, the generalised successor of our fixed 8-bit Johnson user module. It provides:
- configurable width and a programmable step prescaler;
- forward, reverse, hold and parallel-load modes;
- a binary position decode;
- a wrap pulse;
- illegal-state detection with optional self-correction.

It sits behind the Tiny Tapeout top-level wrapper, which maps `ui_in`/`uio_in` onto its controls and `uo_out`/`uio_out` onto its outputs.

## Interface
- `WIDTH`, 4, ring length N (≥2); sequence length 2N
- `DIV_W`, 8, prescaler divisor width
- `SELF_CORRECT`, 1, 1 = an illegal state steps to all-zero instead of shifting
- `POS_W`, derived `$clog2(2*WIDTH)`, position output width

Ports (clock and reset first):
- `clk` in 1: the single clock
- `rst_n` in 1: asynchronous, active-low reset
- `en` in 1: run enable for prescaler and stepping
- `mode` in 2: 00 HOLD, 01 FWD, 10 REV, 11 LOAD
- `div` in DIV_W: a step occurs every div+1 enabled cycles
- `ld_val` in WIDTH: parallel load value
- `clr_err` in 1: clears the sticky error flag
- `q_o` out WIDTH: ring state
- `pos_o` out POS_W: decoded position 0..2N-1
- `wrap_o` out 1: one-cycle pulse on wrap
- `illegal_o` out 1: current `q_o` is not a valid Johnson code
- `err_o` out 1: sticky illegal-state flag

## Operation
- FWD step: `q <= {~q[0], q[N-1:1]}`. For N=4 from 0000: 1000,1100,1110,1111,0111,0011,0001,0000.
- REV step: `q <= {q[N-2:0], ~q[N-1]}`, the exact inverse of FWD.
- Position decode (combinational from `q_o`):
  - 0 if q==0;
  - popcount(q) if q[N-1]=1;
  - otherwise 2N−popcount(q).
  - For illegal states `pos_o` is don't-care.
- Valid Johnson code: at most one index i in 0..N-2 with q[i]≠q[i+1]. `illegal_o` is the combinational negation of this.
- Prescaler `cnt` (DIV_W bits):
  - When en=1 and mode∈{FWD,REV}: if `cnt==div` then tick and `cnt<=0`, else `cnt<=cnt+1`.
  - div=0 gives a tick every enabled cycle.
- Step on tick:
  - If `illegal_o` and SELF_CORRECT=1: `q<=0`.
  - Otherwise shift per mode.
- LOAD (independent of `en`): `q<=ld_val`, `cnt<=0`, no wrap. An illegal `ld_val` is accepted as-is.
- HOLD: `q` is unchanged and `cnt<=0`.
- en=0 in FWD/REV: `q` and `cnt` frozen.
- `wrap_o` is registered, high for one cycle after a step that goes:
  - FWD from position 2N-1 to 0, or
  - REV from position 0 to 2N-1.
  - Never asserted on a self-correct step.
- `err_o`:
  - Set in the cycle after any cycle in which `illegal_o`=1.
  - Cleared by `clr_err`.
  - Set wins over a simultaneous clear.

## Timing
- Reset values: `q_o`=0, `cnt`=0, `pos_o`=0, `wrap_o`=0, `illegal_o`=0, `err_o`=0. Reset takes effect immediately and asynchronously, including mid-count.
- `q_o` updates on the clock edge ending the tick cycle. `pos_o`/`illegal_o` follow with zero additional latency.
- `wrap_o` is asserted in the same cycle the new `q_o` appears.
- Mode changes take effect at the next edge. A FWD↔REV switch does not reset `cnt`.
- Changing `div` mid-count: compare against the new value. If `cnt>div`, `cnt` counts up to wrap at 2^DIV_W−1 → 0, then resumes normally.
- After LOAD of an illegal value: `illegal_o`=1 in the next cycle, `err_o`=1 one cycle later, and correction occurs at the next tick.

## Structure
- Package `johnson_pkg`: mode encoding localparams (`MODE_HOLD`, `MODE_FWD`, `MODE_REV`, `MODE_LOAD`).
- Sub-module `johnson_decode` (combinational, parameter WIDTH): takes q; outputs pos and valid. It is instantiated once in the core and reusable in the bench scoreboard.
- The prescaler, state register and flag logic live in the core.

## Test plan
- Reset mid-run: N=4, div=0, FWD, assert `rst_n`=0 at q=1110 → `q_o`=0000, all flags 0 immediately; after release, q=1000 one enabled cycle later.
- Full FWD cycle: div=0, FWD for 8 cycles from 0000 → `pos_o` 1..7,0 in sequence, `wrap_o` high only in the cycle `q_o` returns to 0000.
- Reverse plus prescaler: div=2, REV from 0000 → q=0001 (pos 7) after 3 cycles, `wrap_o` pulses then; next step 0011 (pos 6) three cycles later.
- Hold and enable: FWD, div=3, drop `en` at cnt=2 for 5 cycles → `q` and `cnt` frozen; switch to HOLD → `cnt`=0, `q` unchanged.
- Illegal load with SELF_CORRECT=1: load 0101 → `illegal_o`=1 next cycle, `err_o`=1 the cycle after; at the next FWD tick q=0000 with no `wrap_o`. A `clr_err` pulse then clears `err_o`.
- Error set/clear collision: hold illegal 1010 with SELF_CORRECT=0, pulse `clr_err` → `err_o` stays 1; load 0000 → `clr_err` clears it.

Source files
------------

// File: rtl/johnson_counter_param_pkg.sv
// Shared mode encoding for the parametrised Johnson counter and its bench.
package johnson_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_FWD  = 2'b01;
    localparam logic [1:0] MODE_REV  = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/johnson_counter_param_if.sv
// Control and status bundle between the Tiny Tapeout wrapper and the counter core.
interface johnson_counter_param_if #(
    parameter int WIDTH = 4,
    parameter int DIV_W = 8,
    parameter int POS_W = $clog2(2 * WIDTH)
);

    logic             en;
    logic [1:0]       mode;
    logic [DIV_W-1:0] div;
    logic [WIDTH-1:0] ld_val;
    logic             clr_err;
    logic [WIDTH-1:0] q_o;
    logic [POS_W-1:0] pos_o;
    logic             wrap_o;
    logic             illegal_o;
    logic             err_o;

    modport master (
        output en, mode, div, ld_val, clr_err,
        input  q_o, pos_o, wrap_o, illegal_o, err_o
    );

    modport slave (
        input  en, mode, div, ld_val, clr_err,
        output q_o, pos_o, wrap_o, illegal_o, err_o
    );

endinterface

// File: rtl/johnson_counter_param_decode.sv
// Combinational Johnson-code decoder: ring position and code validity.
module johnson_decode #(
    parameter int WIDTH = 4,
    parameter int POS_W = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] q_i,
    output logic [POS_W-1:0] pos_o,
    output logic             valid_o
);

    // A legal code has at most one boundary between its run of ones and run of zeros.
    always_comb begin
        int ones;
        int edges;
        ones  = 0;
        edges = 0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + int'(q_i[i]);
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (q_i[i] != q_i[i+1]) begin
                edges = edges + 1;
            end
        end
        valid_o = (edges <= 1);
        if (q_i == '0) begin
            pos_o = '0;
        end else if (q_i[WIDTH-1]) begin
            pos_o = POS_W'(ones);
        end else begin
            pos_o = POS_W'(2 * WIDTH - ones);
        end
    end

endmodule

// File: rtl/johnson_counter_param.sv
// Johnson counter core: prescaled forward/reverse stepping, load, wrap pulse and error flags.
module johnson_counter_param
    import johnson_pkg::*;
#(
    parameter int WIDTH        = 4,
    parameter int DIV_W        = 8,
    parameter int SELF_CORRECT = 1,
    parameter int POS_W        = $clog2(2 * WIDTH)
) (
    input logic                    clk,
    input logic                    rst_n,
    johnson_counter_param_if.slave bus
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic [POS_W-1:0] pos;
    logic             valid;

    johnson_decode #(
        .WIDTH (WIDTH),
        .POS_W (POS_W)
    ) u_decode (
        .q_i     (q_q),
        .pos_o   (pos),
        .valid_o (valid)
    );

    // A wrap is only reported for genuine shifts of a legal code, never for a correction.
    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        unique case (bus.mode)
            MODE_HOLD: begin
                cnt_d = '0;
            end
            MODE_LOAD: begin
                q_d   = bus.ld_val;
                cnt_d = '0;
            end
            default: begin
                if (bus.en) begin
                    if (cnt_q == bus.div) begin
                        cnt_d = '0;
                        if (!valid && (SELF_CORRECT != 0)) begin
                            q_d = '0;
                        end else if (bus.mode == MODE_FWD) begin
                            q_d    = {~q_q[0], q_q[WIDTH-1:1]};
                            wrap_d = (pos == POS_W'(2 * WIDTH - 1));
                        end else begin
                            q_d    = {q_q[WIDTH-2:0], ~q_q[WIDTH-1]};
                            wrap_d = (pos == '0);
                        end
                    end else begin
                        cnt_d = cnt_q + DIV_W'(1);
                    end
                end
            end
        endcase
    end

    // The error flag samples this cycle's illegal state, so a set beats a concurrent clear.
    always_comb begin
        err_d = err_q;
        if (!valid) begin
            err_d = 1'b1;
        end else if (bus.clr_err) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q    <= '0;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign bus.q_o       = q_q;
    assign bus.pos_o     = pos;
    assign bus.wrap_o    = wrap_q;
    assign bus.illegal_o = ~valid;
    assign bus.err_o     = err_q;

endmodule

// File: tb/tb_johnson_counter_param.sv
// Directed scoreboard bench for johnson_counter_param (one self-correcting, one non-correcting instance).
module tb_johnson_counter_param;
    import johnson_pkg::*;

    localparam int F_Q    = 0;
    localparam int F_POS  = 1;
    localparam int F_WRAP = 2;
    localparam int F_ILL  = 3;
    localparam int F_ERR  = 4;

    typedef struct {
        string      tag;
        int         field;
        bit         useB;
        logic [7:0] val;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sb[$];
    int   checkCount;
    int   passCount;

    johnson_counter_param_if #(.WIDTH(4), .DIV_W(8)) busA ();
    johnson_counter_param_if #(.WIDTH(4), .DIV_W(8)) busB ();

    johnson_counter_param #(.WIDTH(4), .DIV_W(8), .SELF_CORRECT(1)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busA)
    );

    johnson_counter_param #(.WIDTH(4), .DIV_W(8), .SELF_CORRECT(0)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Both instances see identical stimulus; inputs change 1ns after the rising edge.
    task automatic applyStimulus(input logic [1:0] m, input logic e, input logic [7:0] d,
                                 input logic [3:0] ld, input logic c, input int cycles);
        busA.mode = m;  busA.en = e;  busA.div = d;  busA.ld_val = ld;  busA.clr_err = c;
        busB.mode = m;  busB.en = e;  busB.div = d;  busB.ld_val = ld;  busB.clr_err = c;
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expectField(input string tag, input int field, input bit useB, input logic [7:0] val);
        exp_t e;
        e.tag = tag;  e.field = field;  e.useB = useB;  e.val = val;
        sb.push_back(e);
    endtask

    function automatic logic [7:0] observe(input int field, input bit useB);
        case (field)
            F_Q:     return useB ? 8'(busB.q_o)       : 8'(busA.q_o);
            F_POS:   return useB ? 8'(busB.pos_o)     : 8'(busA.pos_o);
            F_WRAP:  return useB ? 8'(busB.wrap_o)    : 8'(busA.wrap_o);
            F_ILL:   return useB ? 8'(busB.illegal_o) : 8'(busA.illegal_o);
            default: return useB ? 8'(busB.err_o)     : 8'(busA.err_o);
        endcase
    endfunction

    task automatic checkOutput();
        exp_t       e;
        logic [7:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.field, e.useB);
            checkCount++;
            assert (obs === e.val) passCount++;
            else $error("[TB] FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
        end
    endtask

    initial begin
        logic [3:0] fwdSeq [8];
        fwdSeq = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
        checkCount = 0;
        passCount  = 0;
        rst_n      = 1'b1;
        applyStimulus(MODE_HOLD, 1'b0, 8'd0, 4'd0, 1'b0, 0);

        #2 rst_n = 1'b0;
        #1;
        expectField("reset_q", F_Q, 0, 8'h0);
        expectField("reset_pos", F_POS, 0, 8'h0);
        expectField("reset_wrap", F_WRAP, 0, 8'h0);
        expectField("reset_illegal", F_ILL, 0, 8'h0);
        expectField("reset_err", F_ERR, 0, 8'h0);
        checkOutput();
        @(posedge clk);
        #1 rst_n = 1'b1;

        $display("[TB] full forward cycle, div=0");
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(MODE_FWD, 1'b1, 8'd0, 4'd0, 1'b0, 1);
            expectField($sformatf("fwd_q_%0d", i), F_Q, 0, 8'(fwdSeq[i-1]));
            expectField($sformatf("fwd_pos_%0d", i), F_POS, 0, 8'(i % 8));
            expectField($sformatf("fwd_wrap_%0d", i), F_WRAP, 0, (i == 8) ? 8'h1 : 8'h0);
            checkOutput();
        end

        $display("[TB] reset mid-run");
        applyStimulus(MODE_FWD, 1'b1, 8'd0, 4'd0, 1'b0, 3);
        expectField("prereset_q", F_Q, 0, 8'hE);
        checkOutput();
        rst_n = 1'b0;
        #1;
        expectField("midreset_q", F_Q, 0, 8'h0);
        expectField("midreset_illegal", F_ILL, 0, 8'h0);
        expectField("midreset_wrap", F_WRAP, 0, 8'h0);
        expectField("midreset_err", F_ERR, 0, 8'h0);
        checkOutput();
        @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus(MODE_FWD, 1'b1, 8'd0, 4'd0, 1'b0, 1);
        expectField("postreset_q", F_Q, 0, 8'h8);
        checkOutput();

        $display("[TB] reverse with prescaler div=2");
        applyStimulus(MODE_LOAD, 1'b1, 8'd0, 4'd0, 1'b0, 1);
        applyStimulus(MODE_REV, 1'b1, 8'd2, 4'd0, 1'b0, 2);
        expectField("rev_wait_q", F_Q, 0, 8'h0);
        checkOutput();
        applyStimulus(MODE_REV, 1'b1, 8'd2, 4'd0, 1'b0, 1);
        expectField("rev_step1_q", F_Q, 0, 8'h1);
        expectField("rev_step1_pos", F_POS, 0, 8'd7);
        expectField("rev_step1_wrap", F_WRAP, 0, 8'h1);
        checkOutput();
        applyStimulus(MODE_REV, 1'b1, 8'd2, 4'd0, 1'b0, 1);
        expectField("rev_wrap_drop", F_WRAP, 0, 8'h0);
        checkOutput();
        applyStimulus(MODE_REV, 1'b1, 8'd2, 4'd0, 1'b0, 2);
        expectField("rev_step2_q", F_Q, 0, 8'h3);
        expectField("rev_step2_pos", F_POS, 0, 8'd6);
        checkOutput();

        $display("[TB] enable freeze and hold");
        applyStimulus(MODE_LOAD, 1'b1, 8'd3, 4'd0, 1'b0, 1);
        applyStimulus(MODE_FWD, 1'b1, 8'd3, 4'd0, 1'b0, 2);
        applyStimulus(MODE_FWD, 1'b0, 8'd3, 4'd0, 1'b0, 5);
        expectField("frozen_q", F_Q, 0, 8'h0);
        checkOutput();
        applyStimulus(MODE_FWD, 1'b1, 8'd3, 4'd0, 1'b0, 1);
        expectField("resume_nostep_q", F_Q, 0, 8'h0);
        checkOutput();
        applyStimulus(MODE_FWD, 1'b1, 8'd3, 4'd0, 1'b0, 1);
        expectField("resume_step_q", F_Q, 0, 8'h8);
        checkOutput();
        applyStimulus(MODE_FWD, 1'b1, 8'd3, 4'd0, 1'b0, 2);
        applyStimulus(MODE_HOLD, 1'b1, 8'd3, 4'd0, 1'b0, 1);
        expectField("hold_q", F_Q, 0, 8'h8);
        checkOutput();
        applyStimulus(MODE_FWD, 1'b1, 8'd3, 4'd0, 1'b0, 3);
        expectField("after_hold_nostep_q", F_Q, 0, 8'h8);
        checkOutput();
        applyStimulus(MODE_FWD, 1'b1, 8'd3, 4'd0, 1'b0, 1);
        expectField("after_hold_step_q", F_Q, 0, 8'hC);
        checkOutput();

        $display("[TB] illegal load and self-correction");
        applyStimulus(MODE_LOAD, 1'b1, 8'd1, 4'b0101, 1'b0, 1);
        expectField("ill_load_q", F_Q, 0, 8'h5);
        expectField("ill_load_illegal", F_ILL, 0, 8'h1);
        expectField("ill_load_err", F_ERR, 0, 8'h0);
        checkOutput();
        applyStimulus(MODE_FWD, 1'b1, 8'd1, 4'b0101, 1'b0, 1);
        expectField("ill_err_set", F_ERR, 0, 8'h1);
        expectField("ill_still_q", F_Q, 0, 8'h5);
        checkOutput();
        applyStimulus(MODE_FWD, 1'b1, 8'd1, 4'b0101, 1'b0, 1);
        expectField("corrected_q", F_Q, 0, 8'h0);
        expectField("corrected_wrap", F_WRAP, 0, 8'h0);
        expectField("corrected_illegal", F_ILL, 0, 8'h0);
        expectField("corrected_err", F_ERR, 0, 8'h1);
        expectField("nocorrect_q", F_Q, 1, 8'h2);
        expectField("nocorrect_illegal", F_ILL, 1, 8'h1);
        checkOutput();
        applyStimulus(MODE_HOLD, 1'b1, 8'd1, 4'b0101, 1'b1, 1);
        expectField("clr_err_a", F_ERR, 0, 8'h0);
        checkOutput();

        $display("[TB] error set/clear collision");
        applyStimulus(MODE_LOAD, 1'b1, 8'd0, 4'b1010, 1'b0, 1);
        applyStimulus(MODE_HOLD, 1'b1, 8'd0, 4'b1010, 1'b1, 2);
        expectField("collide_q", F_Q, 1, 8'hA);
        expectField("collide_err", F_ERR, 1, 8'h1);
        checkOutput();
        applyStimulus(MODE_LOAD, 1'b1, 8'd0, 4'b0000, 1'b0, 1);
        expectField("reload_illegal", F_ILL, 1, 8'h0);
        expectField("reload_err_held", F_ERR, 1, 8'h1);
        checkOutput();
        applyStimulus(MODE_HOLD, 1'b1, 8'd0, 4'b0000, 1'b1, 1);
        expectField("final_clr_err", F_ERR, 1, 8'h0);
        checkOutput();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
